cnn_mul_share_arb: RTL and testbench



---
 rtl/cnn_mul_share_pkg.sv | 10 +
 rtl/cnn_rr_arbiter.sv | 35 +++
 rtl/cnn_mul_share_arb.sv | 119 +++++++++++
 tb/tb_cnn_mul_share_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mul_share_pkg.sv
// Shared defaults for the CNN multiplier-sharing arbiter and its
// operation-counter saturation limit.
package cnn_mul_share_pkg;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DIN0_W  = 5;
  localparam int unsigned DEF_DIN1_W  = 7;
  localparam int unsigned DEF_DOUT_W  = 11;
  localparam int unsigned OP_COUNT_W  = 16;
  localparam logic [OP_COUNT_W-1:0] OP_COUNT_MAX = '1;
endpackage

// File: rtl/cnn_rr_arbiter.sv
// Combinational round-robin arbiter: scans req from ptr upward with wrap,
// returns a one-hot grant (gated by en) and the winning index.
module cnn_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found     = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
    // grant_idx stays meaningful when en is low; only the handshake is gated
    if (found && en) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cnn_mul_share_arb.sv
// One unsigned multiplier shared by NUM_REQ requesters through a round-robin
// arbiter and a two-stage (operand, product) pipeline with backpressure.
module cnn_mul_share_arb
  import cnn_mul_share_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned DIN0_W  = DEF_DIN0_W,
  parameter  int unsigned DIN1_W  = DEF_DIN1_W,
  parameter  int unsigned DOUT_W  = DEF_DOUT_W,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DOUT_W-1:0]         rsp_dout,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  output logic [OP_COUNT_W-1:0]     op_count
);

  localparam int unsigned PROD_W = DIN0_W + DIN1_W;
  localparam int unsigned MUL_W  = (PROD_W > DOUT_W) ? PROD_W : DOUT_W;

  logic              s1_v;
  logic [DIN0_W-1:0] s1_a;
  logic [DIN1_W-1:0] s1_b;
  logic [ID_W-1:0]   s1_id;
  logic              s2_v;
  logic [DOUT_W-1:0] s2_p;
  logic [ID_W-1:0]   s2_id;
  logic [ID_W-1:0]   rr_ptr;
  logic [OP_COUNT_W-1:0] cnt;

  logic               adv1;
  logic               adv2;
  logic               accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [MUL_W-1:0]   prod;

  logic [DIN0_W-1:0] din0_arr [NUM_REQ];
  logic [DIN1_W-1:0] din1_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign din0_arr[i] = req_din0[i*DIN0_W +: DIN0_W];
    assign din1_arr[i] = req_din1[i*DIN1_W +: DIN1_W];
  end

  assign adv2 = !s2_v || rsp_ready;
  assign adv1 = !s1_v || adv2;

  // Ready is forced low while reset is held so nothing is accepted mid-reset
  cnn_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .en       (adv1 && ap_rst_n),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  assign prod = MUL_W'(s1_a) * MUL_W'(s1_b);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else if (accept) begin
      s1_v  <= 1'b1;
      s1_a  <= din0_arr[grant_idx];
      s1_b  <= din1_arr[grant_idx];
      s1_id <= grant_idx;
    end else if (adv1) begin
      s1_v  <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s2_v  <= 1'b0;
      s2_p  <= '0;
      s2_id <= '0;
    end else if (adv2) begin
      s2_v  <= s1_v;
      s2_p  <= prod[DOUT_W-1:0];
      s2_id <= s1_id;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
      cnt    <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (cnt != OP_COUNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_dout  = s2_p;
  assign rsp_id    = s2_id;
  assign busy      = s1_v || s2_v;
  assign op_count  = cnt;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Bench for cnn_mul_share_arb: reference model + response queue sampled on the
// falling edge, directed vector table, and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_cnn_mul_share_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DIN0_W  = 5;
  localparam int unsigned DIN1_W  = 7;
  localparam int unsigned DOUT_W  = 11;
  localparam int unsigned ID_W    = 2;

  logic                      ap_clk = 1'b0;
  logic                      ap_rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DIN0_W-1:0] req_din0;
  logic [NUM_REQ*DIN1_W-1:0] req_din1;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DOUT_W-1:0]         rsp_dout;
  logic [ID_W-1:0]           rsp_id;
  logic                      busy;
  logic [15:0]               op_count;

  logic [DIN0_W-1:0] opa [NUM_REQ];
  logic [DIN1_W-1:0] opb [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign req_din0[i*DIN0_W +: DIN0_W] = opa[i];
    assign req_din1[i*DIN1_W +: DIN1_W] = opb[i];
  end

  always #5 ap_clk = ~ap_clk;

  cnn_mul_share_arb #(
    .NUM_REQ(NUM_REQ),
    .DIN0_W (DIN0_W),
    .DIN1_W (DIN1_W),
    .DOUT_W (DOUT_W)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_din0 (req_din0),
    .req_din1 (req_din1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dout (rsp_dout),
    .rsp_id   (rsp_id),
    .busy     (busy),
    .op_count (op_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      opa[i] = DIN0_W'($urandom);
      opb[i] = DIN1_W'($urandom);
    end
  endtask

  // Reference model and in-order response queue
  typedef struct packed {
    logic [DOUT_W-1:0] dout;
    logic [ID_W-1:0]   id;
  } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic        m_s1v, m_s2v, m_adv1, m_adv2, m_found, n2;
  int          m_ptr, m_g;
  logic [15:0] m_cnt;
  logic [31:0] m_rdy, p;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      check("rst_ready", 32'(req_ready), 32'd0);
      m_s1v = 1'b0; m_s2v = 1'b0; m_ptr = 0; m_cnt = '0;
      sb.delete();
    end else begin
      m_adv2  = !m_s2v || rsp_ready;
      m_adv1  = !m_s1v || m_adv2;
      m_found = 1'b0;
      m_g     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (!m_found && req_valid[idx]) begin
          m_found = 1'b1;
          m_g     = idx;
        end
      end
      m_rdy = (m_found && m_adv1) ? (32'd1 << m_g) : 32'd0;
      check("req_ready", 32'(req_ready), m_rdy);
      check("rsp_valid", 32'(rsp_valid), 32'(m_s2v));
      check("busy", 32'(busy), 32'(m_s1v || m_s2v));
      check("op_count", 32'(op_count), 32'(m_cnt));
      if (m_s2v && sb.size() > 0) begin
        check("rsp_dout", 32'(rsp_dout), 32'(sb[0].dout));
        check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        if (rsp_ready) void'(sb.pop_front());
      end
      n2 = m_adv2 ? m_s1v : m_s2v;
      if (m_found && m_adv1) begin
        p      = 32'(opa[m_g]) * 32'(opb[m_g]);
        e.dout = p[DOUT_W-1:0];
        e.id   = ID_W'(m_g);
        sb.push_back(e);
        m_s1v = 1'b1;
        m_ptr = (m_g + 1) % NUM_REQ;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else if (m_adv1) begin
        m_s1v = 1'b0;
      end
      m_s2v = n2;
    end
  end

  typedef struct {
    int r;
    int a;
    int b;
    int dout;
  } vec_t;
  vec_t vecs[6];

  int          hs, acc;
  logic [DOUT_W-1:0] hold_d;
  logic [ID_W-1:0]   hold_id;

  initial begin
    vecs[0] = '{2, 20, 100, 2000};
    vecs[1] = '{1, 31, 127, 1889};
    vecs[2] = '{0, 0, 127, 0};
    vecs[3] = '{3, 31, 1, 31};
    vecs[4] = '{2, 16, 64, 1024};
    vecs[5] = '{1, 17, 121, 9};

    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) tick();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_op_count", 32'(op_count), 32'd0);
    tick();

    // Directed single operations, latency and truncation
    for (int i = 0; i < 6; i++) begin
      opa[vecs[i].r] = DIN0_W'(vecs[i].a);
      opb[vecs[i].r] = DIN1_W'(vecs[i].b);
      req_valid = NUM_REQ'(1) << vecs[i].r;
      hs = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge ap_clk);
        if (req_ready[vecs[i].r]) begin
          hs = c;
          break;
        end
        tick();
      end
      check("vec_accept", 32'(hs == 0), 32'd1);
      tick();
      req_valid = '0;
      @(negedge ap_clk);
      check("vec_latency_early", 32'(rsp_valid), 32'd0);
      @(negedge ap_clk);
      check("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      check("vec_dout", 32'(rsp_dout), 32'(vecs[i].dout));
      check("vec_id", 32'(rsp_id), 32'(vecs[i].r));
      check("vec_op_count", 32'(op_count), 32'(i + 1));
      tick();
    end

    // Round-robin order with all requesters valid
    do_reset();
    req_valid = '1;
    rand_ops();
    for (int i = 0; i < 12; i++) begin
      @(negedge ap_clk);
      check("rr_grant", 32'(req_ready), 32'd1 << (i % NUM_REQ));
      tick();
      rand_ops();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure: two accepts then full stall, outputs held
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    rand_ops();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (|(req_valid & req_ready)) acc++;
      if (i >= 2) check("stall_ready", 32'(req_ready), 32'd0);
      if (i == 2) begin
        hold_d  = rsp_dout;
        hold_id = rsp_id;
      end
      if (i > 2) begin
        check("stall_dout", 32'(rsp_dout), 32'(hold_d));
        check("stall_id", 32'(rsp_id), 32'(hold_id));
      end
      tick();
    end
    check("stall_accepts", 32'(acc), 32'd2);
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) tick();
    @(negedge ap_clk);
    check("stall_drain", 32'(sb.size()), 32'd0);

    // Lone requester 3 wins from ptr 0; pointer wraps to 0
    do_reset();
    req_valid = 4'b1000;
    @(negedge ap_clk);
    check("lone_req3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '1;
    @(negedge ap_clk);
    check("ptr_wrap", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Reset with both stages full
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("full_before_rst", 32'(busy && rsp_valid), 32'd1);
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    rsp_ready = 1'b1;
    repeat (3) tick();
    req_valid = '1;
    @(negedge ap_clk);
    check("midrst_ptr", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    @(negedge ap_clk);
    check("random_drain", 32'(sb.size()), 32'd0);

    // Counter saturation over more than 65535 accepts
    do_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    @(negedge ap_clk);
    check("op_count_sat", 32'(op_count), 32'hFFFF);
    repeat (4) tick();
    @(negedge ap_clk);
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
